// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART TX scheduler and its helpers.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    DATA = 2'd2
  } sched_state_t;

  localparam logic [4:0] TAG_PREFIX = 5'b10100;
  localparam int         GRANT_W    = 3;

  // Header byte announcing which requester owns the following bytes.
  function automatic logic [7:0] tag_byte(input logic [GRANT_W-1:0] id);
    return {TAG_PREFIX, id};
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: first set bit of req strictly after
// index last, scanning upward and wrapping; last itself is checked last.
module rr_pick
  import uart_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]       req,
  input  logic [GRANT_W-1:0] last,
  output logic [GRANT_W-1:0] idx,
  output logic               found
);

  // Distance from the pointer decides priority; smallest distance wins.
  always_comb begin
    int best;
    int off;
    best  = N;
    off   = 0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      off = (i + N - int'(last) - 1) % N;
      if (req[i] && (off < best)) begin
        best  = off;
        idx   = GRANT_W'(i);
        found = 1'b1;
      end else begin
        best  = best;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART TX link among NUM_REQ byte streams.
// Optional header byte per grant when UART_SCHED_TAG_EN is defined.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy
);

  sched_state_t        r_state;
  sched_state_t        w_next_state;
  logic [GRANT_W-1:0]  r_grant_id;
  logic [GRANT_W-1:0]  w_pick_idx;
  logic                w_pick_found;
  logic [7:0]          r_burst_cnt;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;
  logic [7:0]          w_sel_data;
  logic                w_sel_last;
  logic [7:0]          w_load_data;
  logic                w_load;
  logic                w_link_free;
  logic                w_hs;
  logic [NUM_REQ-1:0]  w_req_ready;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .last  (r_grant_id),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  assign w_link_free = !r_tx_valid || tx_ready;

  // Grantee byte mux; only the grantee may see ready, and only once the link can take a byte.
  always_comb begin
    w_sel_data  = 8'h00;
    w_sel_last  = 1'b0;
    w_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == GRANT_W'(i)) begin
        w_sel_data     = req_data[i*8 +: 8];
        w_sel_last     = req_last[i];
        w_req_ready[i] = (r_state == DATA) && w_link_free;
      end else begin
        w_req_ready[i] = 1'b0;
      end
    end
  end

  assign w_hs = |(w_req_ready & req_valid);

  // Next-state and link-load decode.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_data  = w_sel_data;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
`ifdef UART_SCHED_TAG_EN
          w_next_state = TAG;
`else
          w_next_state = DATA;
`endif
        end else begin
          w_next_state = IDLE;
        end
      end
`ifdef UART_SCHED_TAG_EN
      TAG: begin
        if (w_link_free) begin
          w_load       = 1'b1;
          w_load_data  = tag_byte(r_grant_id);
          w_next_state = DATA;
        end else begin
          w_next_state = TAG;
        end
      end
`endif
      DATA: begin
        if (w_hs) begin
          w_load = 1'b1;
          if (w_sel_last || ((r_burst_cnt + 8'd1) == 8'(MAX_BURST))) begin
            w_next_state = IDLE;
          end else begin
            w_next_state = DATA;
          end
        end else begin
          w_next_state = DATA;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grant pointer, burst count and the registered TX link.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_id  <= GRANT_W'(NUM_REQ - 1);
      r_burst_cnt <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      if ((r_state == IDLE) && w_pick_found) begin
        r_grant_id  <= w_pick_idx;
        r_burst_cnt <= 8'h00;
      end else if (w_hs) begin
        r_burst_cnt <= r_burst_cnt + 8'd1;
      end
      if (w_load) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_load_data;
      end else if (tx_ready) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: per-cycle vector table plus stream sequences.
module tb_uart_tx_sched;
  import uart_sched_pkg::*;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0] req_last = '0;
  logic [NR-1:0] req_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b1;
  logic [2:0]    grant_id;
  logic          busy;

  always #5 clk = ~clk;

  uart_tx_sched #(.NUM_REQ(NR), .MAX_BURST(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0] rr;
    logic       tv;
    logic [7:0] td;
    logic [2:0] g;
    logic       b;
  } vec_t;

  vec_t       tbl[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [8:0] src_q[NR][$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       tr_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] rr, input logic tv, input logic [7:0] td,
                         input logic [2:0] g, input logic b);
    vec_t v;
    v.rr = rr; v.tv = tv; v.td = td; v.g = g; v.b = b;
    tbl.push_back(v);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = src_q[i][0][7:0];
        req_last[i]        = src_q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    tx_ready = tr_en;
  endtask

  task automatic cycle();
    logic [NR-1:0] pop;
    logic [8:0]    tmp;
    @(negedge clk);
    pop = req_valid & req_ready;
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (pop[i]) tmp = src_q[i].pop_front();
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    got_q.delete();
    exp_q.delete();
    tr_en = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_pkt(input int r, input logic [7:0] base, input int len);
    for (int k = 0; k < len; k++) src_q[r].push_back({(k == len - 1), base + 8'(k)});
  endtask

  task automatic exp_tag(input int r);
`ifdef UART_SCHED_TAG_EN
    exp_q.push_back({TAG_PREFIX, 3'(r)});
`endif
  endtask

  task automatic exp_bytes(input logic [7:0] base, input int len);
    for (int k = 0; k < len; k++) exp_q.push_back(base + 8'(k));
  endtask

  task automatic run_until(input string name);
    int c;
    logic [31:0] a;
    c = 0;
    while (got_q.size() < exp_q.size() && c < 200) begin
      cycle();
      c++;
    end
    check({name, " count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      a = (k < got_q.size()) ? {24'h0, got_q[k]} : 32'hFFFF_FFFF;
      check($sformatf("%s[%0d]", name, k), a, {24'h0, exp_q[k]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    int c;

    // One-byte packets from every requester: round-robin order 0,1,2,3,0.
`ifdef UART_SCHED_TAG_EN
    add_vec(4'b0000, 1'b0, 8'h00, 3'd3, 1'b0);
    add_vec(4'b0000, 1'b0, 8'h00, 3'd0, 1'b1);
    add_vec(4'b0001, 1'b1, 8'hA0, 3'd0, 1'b1);
    add_vec(4'b0000, 1'b1, 8'h10, 3'd0, 1'b0);
    add_vec(4'b0000, 1'b0, 8'h10, 3'd1, 1'b1);
    add_vec(4'b0010, 1'b1, 8'hA1, 3'd1, 1'b1);
    add_vec(4'b0000, 1'b1, 8'h11, 3'd1, 1'b0);
    add_vec(4'b0000, 1'b0, 8'h11, 3'd2, 1'b1);
`else
    add_vec(4'b0000, 1'b0, 8'h00, 3'd3, 1'b0);
    add_vec(4'b0001, 1'b0, 8'h00, 3'd0, 1'b1);
    add_vec(4'b0000, 1'b1, 8'h10, 3'd0, 1'b0);
    add_vec(4'b0010, 1'b0, 8'h10, 3'd1, 1'b1);
    add_vec(4'b0000, 1'b1, 8'h11, 3'd1, 1'b0);
    add_vec(4'b0100, 1'b0, 8'h11, 3'd2, 1'b1);
    add_vec(4'b0000, 1'b1, 8'h12, 3'd2, 1'b0);
    add_vec(4'b1000, 1'b0, 8'h12, 3'd3, 1'b1);
    add_vec(4'b0000, 1'b1, 8'h13, 3'd3, 1'b0);
    add_vec(4'b0001, 1'b0, 8'h13, 3'd0, 1'b1);
    add_vec(4'b0000, 1'b1, 8'h10, 3'd0, 1'b0);
`endif
    do_reset();
    for (int k = 0; k < tbl.size(); k++) begin
      req_valid = 4'hF;
      req_last  = 4'hF;
      req_data  = 32'h1312_1110;
      tx_ready  = 1'b1;
      @(negedge clk);
      check($sformatf("rr_vec%0d {rdy,tv,td,gnt,busy}", k),
            {15'h0, req_ready, tx_valid, tx_data, grant_id, busy},
            {15'h0, tbl[k].rr, tbl[k].tv, tbl[k].td, tbl[k].g, tbl[k].b});
      @(posedge clk);
      #1;
    end

    // Multi-byte packet stays contiguous ahead of a competing requester.
    do_reset();
    push_pkt(2, 8'h41, 3);
    drive();
    cycle();
    push_pkt(0, 8'h99, 1);
    drive();
    exp_tag(2); exp_bytes(8'h41, 3); exp_tag(0); exp_bytes(8'h99, 1);
    run_until("contig");

    // 20-byte packet is split after 16 bytes to let requester 3 in.
    do_reset();
    push_pkt(1, 8'h20, 20);
    drive();
    cycle();
    push_pkt(3, 8'hC0, 2);
    drive();
    exp_tag(1); exp_bytes(8'h20, 16); exp_tag(3); exp_bytes(8'hC0, 2);
    exp_tag(1); exp_bytes(8'h30, 4);
    run_until("burst");

    // tx_ready low for 5 cycles mid-packet.
    do_reset();
    push_pkt(0, 8'h50, 8);
    drive();
    exp_tag(0); exp_bytes(8'h50, 8);
    repeat (4) cycle();
    tr_en = 1'b0;
    drive();
    held = 8'h00;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check($sformatf("stall%0d tx_valid", s), tx_valid, 1);
      check($sformatf("stall%0d req_ready", s), req_ready, 0);
      if (s == 0) held = tx_data;
      else check($sformatf("stall%0d tx_data", s), tx_data, held);
      @(posedge clk);
      #1;
    end
    tr_en = 1'b1;
    drive();
    run_until("stall");

    // Grant latency from IDLE, and optional tag ahead of the data.
    do_reset();
    push_pkt(3, 8'h55, 1);
    drive();
    #1;
    check("lat idle busy", busy, 0);
    check("lat idle ready", req_ready, 0);
    cycle();
    #1;
`ifdef UART_SCHED_TAG_EN
    check("lat tag ready", req_ready, 0);
    check("lat tag busy", busy, 1);
    cycle();
    #1;
`endif
    check("lat ready", req_ready, 4'b1000);
    check("lat grant", grant_id, 3);
    exp_tag(3); exp_bytes(8'h55, 1);
    run_until("tag");

    // Reset mid-packet with a byte pending on the link.
    do_reset();
    push_pkt(1, 8'h60, 5);
    drive();
    c = 0;
    while (!tx_valid && c < 20) begin
      cycle();
      c++;
    end
    check("rst pre tx_valid", tx_valid, 1);
    rst = 1'b1;
    #1;
    check("rst tx_valid", tx_valid, 0);
    check("rst busy", busy, 0);
    check("rst grant", grant_id, 3);
    check("rst ready", req_ready, 0);
    for (int i = 0; i < NR; i++) src_q[i].delete();
    got_q.delete();
    exp_q.delete();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_pkt(0, 8'h70, 1);
    push_pkt(2, 8'h72, 1);
    drive();
    exp_tag(0); exp_bytes(8'h70, 1); exp_tag(2); exp_bytes(8'h72, 1);
    run_until("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
